// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM states and instruction field positions shared by the core
package cpu_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LOADI, OP_MOV, OP_OUT} opcode_t;
  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;
  localparam int RS1_LSB = 25;
  localparam int RS2_LSB = 18;
  localparam int RD_LSB = 11;
  localparam int IMM_LSB = 3;
  localparam int IMM_W = 8;
  localparam int OP_LSB = 0;
  localparam int OP_W = 3;
  function automatic logic sets_zero(input opcode_t op);
    return op <= OP_XOR;
  endfunction
  function automatic logic sets_carry(input opcode_t op);
    return op == OP_ADD || op == OP_SUB;
  endfunction
endpackage

// File: rtl/alu_param.sv
// alu_param: combinational ALU producing result, zero and carry/borrow
module alu_param
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  opcode_t               opcode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  carry_in,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  carry
);
  logic [DATA_WIDTH:0] sum, diff;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    result = opcode == OP_ADD   ? sum[DATA_WIDTH-1:0] :
             opcode == OP_SUB   ? diff[DATA_WIDTH-1:0] :
             opcode == OP_AND   ? a & b :
             opcode == OP_OR    ? a | b :
             opcode == OP_XOR   ? a ^ b :
             opcode == OP_LOADI ? b : a;
    carry = opcode == OP_ADD ? sum[DATA_WIDTH] :
            opcode == OP_SUB ? diff[DATA_WIDTH] : carry_in;
    zero = ~|result;
  end
endmodule

// File: rtl/cpu_core_param.sv
// cpu_core_param: four-state in-order core with register file, flags and debug read port
module cpu_core_param
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS = 16,
  localparam int REG_AW = $clog2(NUM_REGS)
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic [31:0]           instr_in,
  input  logic                  instr_valid_in,
  output logic                  instr_ready_out,
  output logic                  retire_out,
  output logic [DATA_WIDTH-1:0] cpu_output,
  output logic                  zero_flag_out,
  output logic                  carry_flag_out,
  input  logic [REG_AW-1:0]     dbg_addr_in,
  output logic [DATA_WIDTH-1:0] dbg_data_out
);
  state_t state;
  logic [31:0] instr;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] op_a, op_b, res, alu_res;
  logic res_zero, res_carry, alu_zero, alu_carry, unused_instr;
  opcode_t opcode;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [IMM_W-1:0] imm;
  assign opcode = opcode_t'(instr[OP_LSB +: OP_W]);
  assign rs1 = instr[RS1_LSB +: REG_AW];
  assign rs2 = instr[RS2_LSB +: REG_AW];
  assign rd = instr[RD_LSB +: REG_AW];
  assign imm = instr[IMM_LSB +: IMM_W];
  assign unused_instr = ^instr;
  assign instr_ready_out = state == IDLE;
  assign retire_out = state == WRITEBACK;
  assign dbg_data_out = regs[dbg_addr_in];
  alu_param #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .opcode  (opcode),
    .a       (op_a),
    .b       (op_b),
    .carry_in(carry_flag_out),
    .result  (alu_res),
    .zero    (alu_zero),
    .carry   (alu_carry)
  );
  // regs[0] is never written, so it reads as zero everywhere
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state <= IDLE;
      instr <= '0;
      op_a <= '0;
      op_b <= '0;
      res <= '0;
      res_zero <= 1'b0;
      res_carry <= 1'b0;
      cpu_output <= '0;
      zero_flag_out <= 1'b0;
      carry_flag_out <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid_in) begin
            instr <= instr_in;
            state <= DECODE;
          end
        end
        DECODE: begin
          op_a <= regs[rs1];
          op_b <= opcode == OP_LOADI ? DATA_WIDTH'(imm) : regs[rs2];
          state <= EXECUTE;
        end
        EXECUTE: begin
          res <= alu_res;
          res_zero <= alu_zero;
          res_carry <= alu_carry;
          state <= WRITEBACK;
        end
        WRITEBACK: begin
          if (opcode == OP_OUT) cpu_output <= res;
          else if (rd != '0) regs[rd] <= res;
          if (sets_zero(opcode)) zero_flag_out <= res_zero;
          if (sets_carry(opcode)) carry_flag_out <= res_carry;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_core_param.sv
// tb_cpu_core_param: scoreboard bench for the 8-bit/16-reg and 16-bit/8-reg core builds
module tb_cpu_core_param;
  typedef struct {
    int          rd;
    logic [31:0] val;
    logic [31:0] out;
    logic        z;
    logic        c;
  } exp_t;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3, XOR = 3'd4, LOADI = 3'd5, MOV = 3'd6, OUT = 3'd7;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] instr = '0;
  logic v8 = 1'b0, v16 = 1'b0;
  logic [3:0] dbg8 = '0;
  logic [2:0] dbg16 = '0;
  logic rdy8, ret8, z8, c8, rdy16, ret16, z16, c16;
  logic [7:0] out8, dd8;
  logic [15:0] out16, dd16;
  int checks = 0, errors = 0;
  exp_t q8[$], q16[$];
  logic [31:0] mr [128];
  logic [31:0] mo;
  logic mz, mc;
  int mw, mn;
  bit sel;

  always #5 clk = ~clk;

  cpu_core_param #(.DATA_WIDTH(8), .NUM_REGS(16)) dut8 (
    .clock_in(clk), .reset_in(rst), .instr_in(instr), .instr_valid_in(v8),
    .instr_ready_out(rdy8), .retire_out(ret8), .cpu_output(out8),
    .zero_flag_out(z8), .carry_flag_out(c8), .dbg_addr_in(dbg8), .dbg_data_out(dd8)
  );
  cpu_core_param #(.DATA_WIDTH(16), .NUM_REGS(8)) dut16 (
    .clock_in(clk), .reset_in(rst), .instr_in(instr), .instr_valid_in(v16),
    .instr_ready_out(rdy16), .retire_out(ret16), .cpu_output(out16),
    .zero_flag_out(z16), .carry_flag_out(c16), .dbg_addr_in(dbg16), .dbg_data_out(dd16)
  );

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [6:0] rd, input logic [6:0] rs1,
                                      input logic [6:0] rs2, input logic [7:0] imm);
    return {rs1, rs2, rd, imm, op};
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 128; i++) mr[i] = '0;
    mo = '0;
    mz = 1'b0;
    mc = 1'b0;
  endtask

  task automatic model_step(input logic [31:0] w);
    logic [32:0] mask, a, b, s;
    logic [31:0] r;
    int rs1, rs2, rd;
    exp_t e;
    mask = (33'd1 << mw) - 33'd1;
    rs1 = int'(w[31:25]) % mn;
    rs2 = int'(w[24:18]) % mn;
    rd = int'(w[17:11]) % mn;
    a = {1'b0, mr[rs1]};
    b = {1'b0, mr[rs2]};
    r = '0;
    case (w[2:0])
      ADD: begin s = a + b; r = s[31:0] & mask[31:0]; mc = s > mask; mz = r == 0; end
      SUB: begin s = a - b; r = s[31:0] & mask[31:0]; mc = a < b; mz = r == 0; end
      AND: begin r = a[31:0] & b[31:0]; mz = r == 0; end
      OR:  begin r = a[31:0] | b[31:0]; mz = r == 0; end
      XOR: begin r = a[31:0] ^ b[31:0]; mz = r == 0; end
      LOADI: r = {24'd0, w[10:3]};
      MOV: r = a[31:0];
      default: mo = a[31:0];
    endcase
    if (w[2:0] != OUT && rd != 0) mr[rd] = r;
    e.rd = rd;
    e.val = mr[rd];
    e.out = mo;
    e.z = mz;
    e.c = mc;
    if (sel) q16.push_back(e);
    else q8.push_back(e);
  endtask

  always begin
    @(negedge clk);
    if (ret8 === 1'b1) begin : mon8
      exp_t e;
      @(negedge clk);
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL mon8_retire: retire with no pending instruction");
      end else begin
        e = q8.pop_front();
        dbg8 = e.rd[3:0];
        #1;
        checks += 3;
        if (32'(dd8) !== e.val) begin errors++; $display("FAIL mon8_reg: r%0d=%0h, required %0h", e.rd, dd8, e.val); end
        if (32'(out8) !== e.out) begin errors++; $display("FAIL mon8_out: cpu_output=%0h, required %0h", out8, e.out); end
        if ({z8, c8} !== {e.z, e.c}) begin errors++; $display("FAIL mon8_flags: z,c=%b%b, required %b%b", z8, c8, e.z, e.c); end
      end
    end
  end

  always begin
    @(negedge clk);
    if (ret16 === 1'b1) begin : mon16
      exp_t e;
      @(negedge clk);
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL mon16_retire: retire with no pending instruction");
      end else begin
        e = q16.pop_front();
        dbg16 = e.rd[2:0];
        #1;
        checks += 3;
        if (32'(dd16) !== e.val) begin errors++; $display("FAIL mon16_reg: r%0d=%0h, required %0h", e.rd, dd16, e.val); end
        if (32'(out16) !== e.out) begin errors++; $display("FAIL mon16_out: cpu_output=%0h, required %0h", out16, e.out); end
        if ({z16, c16} !== {e.z, e.c}) begin errors++; $display("FAIL mon16_flags: z,c=%b%b, required %b%b", z16, c16, e.z, e.c); end
      end
    end
  end

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    instr = w;
    if (sel) v16 = 1'b1;
    else v8 = 1'b1;
    while ((sel ? rdy16 : rdy8) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_ready: ready=0 for %0d cycles, required 1", n);
    end else begin
      model_step(w);
      @(posedge clk);
      #1;
    end
    v8 = 1'b0;
    v16 = 1'b0;
  endtask

  task automatic drain(input bit s);
    int n;
    n = 0;
    while ((s ? q16.size() : q8.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL drain: %0d results still pending, required 0", s ? q16.size() : q8.size());
    end
    @(negedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ret8, ret16} !== 2'b00) begin errors++; $display("FAIL reset_retire: retire=%b, required 00", {ret8, ret16}); end
    rst = 1'b0;
    dbg8 = 4'd9;
    dbg16 = 3'd5;
    #1;
    checks += 4;
    if ({rdy8, rdy16} !== 2'b11) begin errors++; $display("FAIL reset_ready: ready=%b, required 11", {rdy8, rdy16}); end
    if (out8 !== 8'h00 || out16 !== 16'h0000) begin errors++; $display("FAIL reset_out: out=%0h/%0h, required 0", out8, out16); end
    if ({z8, c8, z16, c16} !== 4'b0000) begin errors++; $display("FAIL reset_flags: flags=%b, required 0000", {z8, c8, z16, c16}); end
    if (dd8 !== 8'h00 || dd16 !== 16'h0000) begin errors++; $display("FAIL reset_regs: dbg=%0h/%0h, required 0", dd8, dd16); end
  endtask

  task automatic test_arith;
    sel = 1'b0;
    send(enc(LOADI, 1, 0, 0, 8'd200));
    send(enc(LOADI, 2, 0, 0, 8'd100));
    send(enc(ADD, 3, 1, 2, 0));
    send(enc(SUB, 4, 2, 2, 0));
    send(enc(SUB, 5, 2, 1, 0));
    send(enc(AND, 7, 1, 2, 0));
    send(enc(OR, 8, 1, 2, 0));
    send(enc(XOR, 2, 2, 1, 0));
    send(enc(MOV, 9, 5, 0, 0));
    drain(1'b0);
    dbg8 = 4'd3;
    #1;
    checks++;
    if (dd8 !== 8'd44) begin errors++; $display("FAIL arith_add_wrap: r3=%0d, required 44", dd8); end
    dbg8 = 4'd4;
    #1;
    checks++;
    if (dd8 !== 8'd0) begin errors++; $display("FAIL arith_sub_zero: r4=%0d, required 0", dd8); end
    dbg8 = 4'd5;
    #1;
    checks++;
    if (dd8 !== 8'd156) begin errors++; $display("FAIL arith_sub_borrow: r5=%0d, required 156", dd8); end
  endtask

  task automatic test_r0_out;
    sel = 1'b0;
    send(enc(LOADI, 0, 0, 0, 8'd55));
    send(enc(OUT, 0, 0, 0, 0));
    send(enc(LOADI, 6, 0, 0, 8'hA5));
    send(enc(OUT, 0, 6, 0, 0));
    drain(1'b0);
    dbg8 = 4'd0;
    #1;
    checks += 2;
    if (dd8 !== 8'h00) begin errors++; $display("FAIL r0_hardwired: r0=%0h, required 0", dd8); end
    if (out8 !== 8'hA5) begin errors++; $display("FAIL out_value: cpu_output=%0h, required a5", out8); end
  endtask

  task automatic test_handshake;
    int low, last_ret, accepts;
    logic [31:0] w;
    low = 0;
    last_ret = -1;
    accepts = 0;
    sel = 1'b0;
    for (int cyc = 0; cyc < 48; cyc++) begin
      @(negedge clk);
      w = $urandom();
      instr = w;
      v8 = 1'b1;
      if (rdy8) begin
        if (accepts > 0) begin
          checks++;
          if (low != 3) begin errors++; $display("FAIL hs_ready_low: ready low %0d cycles, required 3", low); end
        end
        model_step(w);
        accepts++;
        low = 0;
      end else low++;
      if (ret8) begin
        if (last_ret >= 0) begin
          checks++;
          if (cyc - last_ret != 4) begin errors++; $display("FAIL hs_retire_gap: gap %0d cycles, required 4", cyc - last_ret); end
        end
        last_ret = cyc;
      end
    end
    @(negedge clk);
    v8 = 1'b0;
    checks++;
    if (accepts != 12) begin errors++; $display("FAIL hs_accepts: %0d accepts, required 12", accepts); end
    drain(1'b0);
  endtask

  task automatic test_reset_mid;
    sel = 1'b0;
    send(enc(LOADI, 1, 0, 0, 8'd200));
    send(enc(LOADI, 2, 0, 0, 8'd100));
    send(enc(OUT, 0, 1, 0, 0));
    drain(1'b0);
    send(enc(ADD, 3, 1, 2, 0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    instr = enc(LOADI, 9, 0, 0, 8'd7);
    v8 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    v8 = 1'b0;
    q8.delete();
    model_reset();
    dbg8 = 4'd3;
    #1;
    checks += 5;
    if (rdy8 !== 1'b1) begin errors++; $display("FAIL rstmid_ready: ready=%b, required 1", rdy8); end
    if (ret8 !== 1'b0) begin errors++; $display("FAIL rstmid_retire: retire=%b, required 0", ret8); end
    if (dd8 !== 8'h00) begin errors++; $display("FAIL rstmid_r3: r3=%0h, required 0", dd8); end
    if (out8 !== 8'h00) begin errors++; $display("FAIL rstmid_out: cpu_output=%0h, required 0", out8); end
    if ({z8, c8} !== 2'b00) begin errors++; $display("FAIL rstmid_flags: z,c=%b%b, required 00", z8, c8); end
    dbg8 = 4'd9;
    #1;
    checks++;
    if (dd8 !== 8'h00) begin errors++; $display("FAIL rstmid_r9: r9=%0h, required 0", dd8); end
  endtask

  task automatic test_w16;
    sel = 1'b1;
    mw = 16;
    mn = 8;
    model_reset();
    send(enc(LOADI, 1, 0, 0, 8'd255));
    send(enc(ADD, 2, 7'b0001001, 1, 0));
    send(enc(LOADI, 3, 0, 0, 8'd255));
    repeat (8) send(enc(ADD, 3, 3, 3, 0));
    send(enc(LOADI, 5, 0, 0, 8'd255));
    send(enc(ADD, 3, 3, 5, 0));
    send(enc(LOADI, 1, 0, 0, 8'd1));
    send(enc(ADD, 4, 3, 1, 0));
    drain(1'b1);
    dbg16 = 3'd2;
    #1;
    checks++;
    if (dd16 !== 16'd510) begin errors++; $display("FAIL w16_r2: r2=%0d, required 510", dd16); end
    dbg16 = 3'd3;
    #1;
    checks++;
    if (dd16 !== 16'hFFFF) begin errors++; $display("FAIL w16_r3: r3=%0h, required ffff", dd16); end
    dbg16 = 3'd4;
    #1;
    checks += 2;
    if (dd16 !== 16'h0000) begin errors++; $display("FAIL w16_r4: r4=%0h, required 0", dd16); end
    if ({z16, c16} !== 2'b11) begin errors++; $display("FAIL w16_flags: z,c=%b%b, required 11", z16, c16); end
  endtask

  initial begin
    sel = 1'b0;
    mw = 8;
    mn = 16;
    model_reset();
    test_reset();
    test_arith();
    test_r0_out();
    test_handshake();
    test_reset_mid();
    test_w16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
